// File: rtl/heart_rate_pkg.sv
// Shared types and constants for the heart-rate measurement path.
package heart_rate_pkg;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        REFRACT    = 2'd1,
        MEASURE    = 2'd2,
        DIVIDE     = 2'd3
    } state_e;

    localparam logic [15:0] MS_PER_MIN = 16'd60000;

    // Clamp a 16-bit rate to the 8-bit output range.
    function automatic logic [7:0] sat_u8(input logic [15:0] v);
        return (v > 16'd255) ? 8'd255 : v[7:0];
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned 16/16 restoring divider: one quotient bit per cycle, 16 iterations,
// quotient held after the done pulse.
module seq_divider
    import heart_rate_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic        done
);

    logic [15:0] rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] div_q, div_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [16:0] shifted;
    logic [16:0] trial;

    // quo_q shifts the dividend out at the top while quotient bits enter at the bottom.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[15]};
        trial   = shifted - {1'b0, div_q};
        if (start) begin
            rem_d  = 16'd0;
            quo_d  = dividend;
            div_d  = divisor;
            cnt_d  = 5'd16;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!trial[16]) begin
                rem_d = trial[15:0];
                quo_d = {quo_q[14:0], 1'b1};
            end else begin
                rem_d = shifted[15:0];
                quo_d = {quo_q[14:0], 1'b0};
            end
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/beat_rate_meter.sv
// Beat detection with refractory rejection, millisecond interval timing and
// 60000/interval BPM computation; flags signal loss after a timeout.
module beat_rate_meter
    import heart_rate_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned REFRACT_MS = 250,
    parameter int unsigned TIMEOUT_MS = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       over,
    output logic       beat,
    output logic [7:0] bpm,
    output logic       bpm_valid,
    output logic       no_signal
);

    localparam int          PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
    localparam logic [15:0] REFRACT_C = 16'(REFRACT_MS);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_MS);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ms_cnt_q, ms_cnt_d;
    logic          over_q;
    logic          beat_q, beat_d;
    logic [7:0]    bpm_q, bpm_d;
    logic          bpm_valid_q, bpm_valid_d;
    logic          no_signal_q, no_signal_d;
    logic          tick, rise, clear_ms, div_start, div_done;
    logic [15:0]   quotient;

    assign tick    = (presc_q == PRESC_TC);
    assign presc_d = tick ? '0 : presc_q + 1'b1;
    assign rise    = over & ~over_q;

    // A beat restarts the interval; otherwise count ms and park at the timeout.
    always_comb begin
        ms_cnt_d = ms_cnt_q;
        if (clear_ms)
            ms_cnt_d = 16'd0;
        else if (tick && (ms_cnt_q != TIMEOUT_C))
            ms_cnt_d = ms_cnt_q + 16'd1;
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = 1'b0;
        bpm_valid_d = 1'b0;
        bpm_d       = bpm_q;
        no_signal_d = no_signal_q;
        clear_ms    = 1'b0;
        div_start   = 1'b0;
        case (state_q)
            WAIT_FIRST: begin
                if (rise) begin
                    beat_d      = 1'b1;
                    clear_ms    = 1'b1;
                    no_signal_d = 1'b0;
                    state_d     = REFRACT;
                end
            end
            REFRACT: begin
                if (ms_cnt_q >= REFRACT_C)
                    state_d = MEASURE;
            end
            MEASURE: begin
                // A beat landing on the timeout cycle still counts as a beat.
                if (rise) begin
                    beat_d    = 1'b1;
                    clear_ms  = 1'b1;
                    div_start = 1'b1;
                    state_d   = DIVIDE;
                end else if (ms_cnt_q == TIMEOUT_C) begin
                    no_signal_d = 1'b1;
                    state_d     = WAIT_FIRST;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    bpm_d       = sat_u8(quotient);
                    bpm_valid_d = 1'b1;
                    state_d     = REFRACT;
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_FIRST;
            presc_q     <= '0;
            ms_cnt_q    <= '0;
            over_q      <= 1'b0;
            beat_q      <= 1'b0;
            bpm_q       <= '0;
            bpm_valid_q <= 1'b0;
            no_signal_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            ms_cnt_q    <= ms_cnt_d;
            over_q      <= over;
            beat_q      <= beat_d;
            bpm_q       <= bpm_d;
            bpm_valid_q <= bpm_valid_d;
            no_signal_q <= no_signal_d;
        end
    end

    // The interval is captured by the divider on the start pulse.
    seq_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (MS_PER_MIN),
        .divisor  (ms_cnt_q),
        .quotient (quotient),
        .done     (div_done)
    );

    assign beat      = beat_q;
    assign bpm       = bpm_q;
    assign bpm_valid = bpm_valid_q;
    assign no_signal = no_signal_q;

endmodule

// File: tb/tb_beat_rate_meter.sv
// Directed, table-driven bench for beat_rate_meter with TICK_DIV=4.
module tb_beat_rate_meter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       over = 1'b0;
    logic       beat;
    logic [7:0] bpm;
    logic       bpm_valid;
    logic       no_signal;

    always #5 clk = ~clk;

    beat_rate_meter #(
        .TICK_DIV   (4),
        .REFRACT_MS (250),
        .TIMEOUT_MS (3000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .over      (over),
        .beat      (beat),
        .bpm       (bpm),
        .bpm_valid (bpm_valid),
        .no_signal (no_signal)
    );

    // Edges since reset release; the prescaler ticks on edges where cyc%4==3
    // beforehand, so beats placed at cyc%4==1 see exactly gap_ms ticks.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int valid_cnt = 0;
    int beat_cnt  = 0;
    always @(negedge clk) begin
        if (bpm_valid === 1'b1) valid_cnt = valid_cnt + 1;
        if (beat === 1'b1)      beat_cnt  = beat_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    int last_beat = 0;
    int exp_valid_total = 0;
    int exp_beat_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        int         gap_ms;
        bit         first;
        bit         accept;
        bit         exp_valid;
        logic [7:0] exp_bpm;
        bit         exp_nosig_pre;
    } vec_t;

    function automatic vec_t mk(input string n, input int gap, input bit first, input bit acc,
                                input bit val, input logic [7:0] b, input bit pre);
        vec_t v;
        v.name = n; v.gap_ms = gap; v.first = first; v.accept = acc;
        v.exp_valid = val; v.exp_bpm = b; v.exp_nosig_pre = pre;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        int  target;
        logic exp_nosig_post;
        if (v.first) begin
            target = cyc + 4;
            while (target % 4 != 1) target++;
        end else begin
            target = last_beat + 4 * v.gap_ms;
        end
        while (cyc < target) @(negedge clk);
        check({v.name, " no_signal_pre"}, 32'(no_signal), 32'(v.exp_nosig_pre));
        over = 1'b1;
        @(negedge clk);
        check({v.name, " beat"}, 32'(beat), 32'(v.accept));
        if (v.accept) begin
            last_beat = target;
            exp_beat_total++;
        end
        @(negedge clk);
        @(negedge clk);
        over = 1'b0;
        while (cyc < target + 17) @(negedge clk);
        check({v.name, " valid_early"}, 32'(bpm_valid), 32'd0);
        @(negedge clk);
        check({v.name, " bpm_valid"}, 32'(bpm_valid), 32'(v.exp_valid));
        check({v.name, " bpm"}, 32'(bpm), 32'(v.exp_bpm));
        exp_nosig_post = v.accept ? 1'b0 : v.exp_nosig_pre;
        check({v.name, " no_signal_post"}, 32'(no_signal), 32'(exp_nosig_post));
        if (v.exp_valid) exp_valid_total++;
        @(negedge clk);
        check({v.name, " valid_count"}, 32'(valid_cnt), 32'(exp_valid_total));
        check({v.name, " beat_count"}, 32'(beat_cnt), 32'(exp_beat_total));
        $display("vec %s gap=%0d beat=%0d bpm=%0d no_signal=%0d", v.name, v.gap_ms, v.accept, bpm, no_signal);
    endtask

    vec_t vecs[9];
    int   target;

    initial begin
        vecs[0] = mk("first",    0,    1'b1, 1'b1, 1'b0, 8'd0,   1'b1);
        vecs[1] = mk("1000ms",   1000, 1'b0, 1'b1, 1'b1, 8'd60,  1'b0);
        vecs[2] = mk("750ms",    750,  1'b0, 1'b1, 1'b1, 8'd80,  1'b0);
        vecs[3] = mk("250ms",    250,  1'b0, 1'b1, 1'b1, 8'd240, 1'b0);
        vecs[4] = mk("2999ms",   2999, 1'b0, 1'b1, 1'b1, 8'd20,  1'b0);
        vecs[5] = mk("glitch",   100,  1'b0, 1'b0, 1'b0, 8'd20,  1'b0);
        vecs[6] = mk("postglt",  1000, 1'b0, 1'b1, 1'b1, 8'd60,  1'b0);
        vecs[7] = mk("timeout",  3100, 1'b0, 1'b1, 1'b0, 8'd60,  1'b1);
        vecs[8] = mk("500ms",    500,  1'b0, 1'b1, 1'b1, 8'd120, 1'b0);

        repeat (3) @(negedge clk);
        check("rst beat", 32'(beat), 32'd0);
        check("rst bpm", 32'(bpm), 32'd0);
        check("rst bpm_valid", 32'(bpm_valid), 32'd0);
        check("rst no_signal", 32'(no_signal), 32'd1);
        $display("reset state beat=%0d bpm=%0d valid=%0d no_signal=%0d", beat, bpm, bpm_valid, no_signal);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

        // Reset while the divider is busy: outputs clear at once, no late result.
        target = last_beat + 4000;
        while (cyc < target) @(negedge clk);
        over = 1'b1;
        @(negedge clk);
        check("divrst beat", 32'(beat), 32'd1);
        exp_beat_total++;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("divrst beat_clr", 32'(beat), 32'd0);
        check("divrst bpm_clr", 32'(bpm), 32'd0);
        check("divrst valid_clr", 32'(bpm_valid), 32'd0);
        check("divrst no_signal_set", 32'(no_signal), 32'd1);
        $display("reset during divide bpm=%0d no_signal=%0d", bpm, no_signal);
        over = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("divrst no_late_valid", 32'(valid_cnt), 32'(exp_valid_total));
        check("divrst bpm_held0", 32'(bpm), 32'd0);

        apply_vec(mk("rfirst", 0,    1'b1, 1'b1, 1'b0, 8'd0,  1'b1));
        apply_vec(mk("r1000",  1000, 1'b0, 1'b1, 1'b1, 8'd60, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
